// File: rtl/prng_seq_ctrl.sv
// prng_seq_ctrl: sequencing controller for the PRNG datapath.
// Issues single-cycle clock-enable strobes to the 16-bit data LFSR and the
// 8-bit control LFSR. It also produces the seed parallel-load strobe and the
// display-latch strobe, and tracks the number of data steps since the last seed.
// Everything runs in the CLK domain.
// Optional build macro PRNG_DEBOUNCE_EN: adds a stability-counter debouncer
// (DEB_CYCLES samples) between the button synchroniser and the edge detector.
module prng_seq_ctrl #(
    parameter logic [23:0] DATA_DIV = 24'd10_000_000,
    parameter logic [23:0] CTRL_DIV = 24'd4
`ifdef PRNG_DEBOUNCE_EN
    ,
    parameter logic [15:0] DEB_CYCLES = 16'd50_000
`endif
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        en,
    input  logic        mode_run,
    input  logic        step_btn,
    input  logic        seed_req,
    input  logic [7:0]  seed_val,
    output logic        data_step,
    output logic        ctrl_step,
    output logic        seed_load,
    output logic [15:0] seed_data,
    output logic        disp_latch,
    output logic [1:0]  state,
    output logic [7:0]  step_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SEED  = 2'b01,
        RUN   = 2'b10,
        PAUSE = 2'b11
    } state_t;

    typedef struct packed {
        logic data;
        logic ctrl;
        logic load;
    } strobe_t;

    state_t      state_q, state_d;
    logic [23:0] ddiv_q, ddiv_d;
    logic [23:0] cdiv_q, cdiv_d;
    logic [7:0]  cnt_q;
    logic        lat_q;
    strobe_t     stb;

    logic        btn_s1, btn_s2, btn_prev;
    logic        btn_lvl, btn_edge;

    // Two-flop synchroniser on the raw asynchronous button.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= step_btn;
            btn_s2 <= btn_s1;
        end
    end

`ifdef PRNG_DEBOUNCE_EN
    logic        deb_q;
    logic [15:0] deb_cnt;

    // Debounced level flips only after DEB_CYCLES consecutive samples that
    // disagree with it; any agreeing sample restarts the window.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else if (btn_s2 == deb_q) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_CYCLES - 16'd1) begin
            deb_q   <= btn_s2;
            deb_cnt <= '0;
        end else begin
            deb_cnt <= deb_cnt + 16'd1;
        end
    end

    assign btn_lvl = deb_q;
`else
    assign btn_lvl = btn_s2;
`endif

    // Previous-value flop for rising-edge detection on the button level.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) btn_prev <= 1'b0;
        else      btn_prev <= btn_lvl;
    end

    assign btn_edge = btn_lvl & ~btn_prev;

    // Next-state, divider and strobe decode; en=0 overrides everything.
    always_comb begin
        state_d = state_q;
        ddiv_d  = ddiv_q;
        cdiv_d  = cdiv_q;
        stb     = '0;
        if (!en) begin
            state_d = IDLE;
            ddiv_d  = '0;
            cdiv_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (seed_req)      state_d = SEED;
                    else if (mode_run) state_d = RUN;
                    else               state_d = PAUSE;
                end
                SEED: begin
                    stb.load = 1'b1;
                    ddiv_d   = '0;
                    cdiv_d   = '0;
                    if (seed_req)      state_d = SEED;
                    else if (mode_run) state_d = RUN;
                    else               state_d = PAUSE;
                end
                RUN: begin
                    if (seed_req) begin
                        // A terminal count in this cycle is dropped on purpose.
                        state_d = SEED;
                        ddiv_d  = '0;
                        cdiv_d  = '0;
                    end else begin
                        if (ddiv_q == DATA_DIV - 24'd1) begin
                            stb.data = 1'b1;
                            ddiv_d   = '0;
                        end else begin
                            ddiv_d = ddiv_q + 24'd1;
                        end
                        if (cdiv_q == CTRL_DIV - 24'd1) begin
                            stb.ctrl = 1'b1;
                            cdiv_d   = '0;
                        end else begin
                            cdiv_d = cdiv_q + 24'd1;
                        end
                        state_d = mode_run ? RUN : PAUSE;
                    end
                end
                PAUSE: begin
                    // Dividers hold so RUN resumes mid-period.
                    if (seed_req) begin
                        state_d = SEED;
                    end else begin
                        if (btn_edge) begin
                            stb.data = 1'b1;
                            stb.ctrl = 1'b1;
                        end
                        state_d = mode_run ? RUN : PAUSE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and divider registers.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ddiv_q  <= '0;
            cdiv_q  <= '0;
        end else begin
            state_q <= state_d;
            ddiv_q  <= ddiv_d;
            cdiv_q  <= cdiv_d;
        end
    end

    // Step counter: cleared by seed load, bumped by every data step, wraps.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst)          cnt_q <= '0;
        else if (stb.load) cnt_q <= '0;
        else if (stb.data) cnt_q <= cnt_q + 8'd1;
    end

    // Display latch trails every data step / seed load by one cycle.
    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) lat_q <= 1'b0;
        else      lat_q <= stb.data | stb.load;
    end

    // The seed word has a 0 in its low byte wherever the high byte has a 1,
    // so it can never be the all-ones XNOR-LFSR lock-up value.
    assign data_step  = stb.data;
    assign ctrl_step  = stb.ctrl;
    assign seed_load  = stb.load;
    assign seed_data  = stb.load ? {seed_val, ~seed_val} : 16'h0000;
    assign disp_latch = lat_q & en;
    assign state      = state_q;
    assign step_count = cnt_q;

endmodule

// File: tb/tb_prng_seq_ctrl.sv
// tb_prng_seq_ctrl: directed scoreboard bench for prng_seq_ctrl.
// DATA_DIV=8, CTRL_DIV=3 (DEB_CYCLES=4 when PRNG_DEBOUNCE_EN is defined).
// Expected strobe cycles are pushed per output queue by the stimulus. A
// negedge monitor pops an entry whenever that strobe is seen, and compares.
module tb_prng_seq_ctrl;

    localparam logic [23:0] DD = 24'd8;
    localparam logic [23:0] CD = 24'd3;
`ifdef PRNG_DEBOUNCE_EN
    localparam int BL = 4;
`else
    localparam int BL = 0;
`endif

    logic        CLK = 1'b0;
    logic        rst, en, mode_run, step_btn, seed_req;
    logic [7:0]  seed_val;
    logic        data_step, ctrl_step, seed_load, disp_latch;
    logic [15:0] seed_data;
    logic [1:0]  state;
    logic [7:0]  step_count;

    typedef struct {
        int          c;
        logic [15:0] d;
    } ld_t;

    int  cyc    = 0;
    int  n_cmp  = 0;
    int  n_fail = 0;
    int  qd[$], qc[$], qp[$];
    ld_t ql[$];
    int  me;
    ld_t le;

    prng_seq_ctrl #(
        .DATA_DIV(DD),
        .CTRL_DIV(CD)
`ifdef PRNG_DEBOUNCE_EN
        ,
        .DEB_CYCLES(16'd4)
`endif
    ) dut (
        .CLK       (CLK),
        .rst       (rst),
        .en        (en),
        .mode_run  (mode_run),
        .step_btn  (step_btn),
        .seed_req  (seed_req),
        .seed_val  (seed_val),
        .data_step (data_step),
        .ctrl_step (ctrl_step),
        .seed_load (seed_load),
        .seed_data (seed_data),
        .disp_latch(disp_latch),
        .state     (state),
        .step_count(step_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic go(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) go(1);
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pop and compare whenever a strobe is presented.
    always @(negedge CLK) begin
        if (data_step) begin
            n_cmp++;
            if (qd.size() == 0) begin
                n_fail++;
                $display("FAIL data_step: pulse at cycle %0d, none expected", cyc);
            end else begin
                me = qd.pop_front();
                if (me != cyc) begin
                    n_fail++;
                    $display("FAIL data_step: pulse at cycle %0d, expected cycle %0d", cyc, me);
                end
            end
        end
        if (ctrl_step) begin
            n_cmp++;
            if (qc.size() == 0) begin
                n_fail++;
                $display("FAIL ctrl_step: pulse at cycle %0d, none expected", cyc);
            end else begin
                me = qc.pop_front();
                if (me != cyc) begin
                    n_fail++;
                    $display("FAIL ctrl_step: pulse at cycle %0d, expected cycle %0d", cyc, me);
                end
            end
        end
        if (disp_latch) begin
            n_cmp++;
            if (qp.size() == 0) begin
                n_fail++;
                $display("FAIL disp_latch: pulse at cycle %0d, none expected", cyc);
            end else begin
                me = qp.pop_front();
                if (me != cyc) begin
                    n_fail++;
                    $display("FAIL disp_latch: pulse at cycle %0d, expected cycle %0d", cyc, me);
                end
            end
        end
        if (seed_load) begin
            n_cmp++;
            if (ql.size() == 0) begin
                n_fail++;
                $display("FAIL seed_load: pulse at cycle %0d data %h, none expected", cyc, seed_data);
            end else begin
                le = ql.pop_front();
                if (le.c != cyc || le.d !== seed_data) begin
                    n_fail++;
                    $display("FAIL seed_load: cycle %0d data %h, expected cycle %0d data %h",
                             cyc, seed_data, le.c, le.d);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int A, R, C, P;
        rst = 1'b0; en = 1'b1; mode_run = 1'b1; step_btn = 1'b0;
        seed_req = 1'b1; seed_val = 8'hA5;
        go(3);
        chk("reset state", 16'(state), 16'd0);
        chk("reset step_count", 16'(step_count), 16'd0);
        chk("reset seed_data", seed_data, 16'h0000);
        chk("reset strobes", 16'({data_step, ctrl_step, seed_load, disp_latch}), 16'd0);

        // Free run from IDLE: data every 8, ctrl every 3, latch one after data.
        A = cyc;
        rst = 1'b1; seed_req = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            qd.push_back(A + 8 * k);
            qp.push_back(A + 8 * k + 1);
        end
        for (int j = 1; j <= 11; j++) qc.push_back(A + 3 * j);
        chk("idle before run", 16'(state), 16'd0);
        at(A + 1);
        chk("run entered", 16'(state), 16'd2);
        at(A + 33);
        chk("step_count after 32 run cycles", 16'(step_count), 16'd4);

        // One-cycle seed request mid-run.
        at(A + 34);
        seed_req = 1'b1;
        ql.push_back('{A + 35, 16'hA55A});
        qp.push_back(A + 36);
        at(A + 35);
        seed_req = 1'b0;
        chk("seed state", 16'(state), 16'd1);
        at(A + 36);
        chk("step_count cleared by seed", 16'(step_count), 16'd0);
        chk("run after seed", 16'(state), 16'd2);
        qd.push_back(A + 43);
        qp.push_back(A + 44);
        qc.push_back(A + 38); qc.push_back(A + 41); qc.push_back(A + 44);

        // Pause (data div held at 2, ctrl div at 1), three clean presses.
        at(A + 45);
        mode_run = 1'b0;
        at(A + 46);
        chk("pause entered", 16'(state), 16'd3);
        for (int p = 0; p < 3; p++) begin
            P = A + 48 + 12 * p;
            at(P);
            step_btn = 1'b1;
            qd.push_back(P + 2 + BL);
            qc.push_back(P + 2 + BL);
            qp.push_back(P + 3 + BL);
            at(P + 6);
            step_btn = 1'b0;
        end
        at(A + 82);
        chk("step_count after presses", 16'(step_count), 16'd4);

        // Resume run from held dividers.
        R = A + 84;
        at(R);
        mode_run = 1'b1;
        qd.push_back(R + 6);
        qp.push_back(R + 7);
        qc.push_back(R + 2); qc.push_back(R + 5); qc.push_back(R + 8); qc.push_back(R + 11);

        // en dropped on a coincident data/ctrl terminal count.
        at(R + 14);
        en = 1'b0;
        at(R + 15);
        en = 1'b1;
        chk("idle after en drop", 16'(state), 16'd0);
        chk("step_count held through en drop", 16'(step_count), 16'd5);
        qd.push_back(R + 23);
        qp.push_back(R + 24);
        for (int j = 0; j < 5; j++) qc.push_back(R + 18 + 3 * j);

        // Seed request on a data terminal count: only seed_load fires.
        at(R + 31);
        seed_req = 1'b1;
        seed_val = 8'h3C;
        ql.push_back('{R + 32, 16'h3CC3});
        qp.push_back(R + 33);
        at(R + 32);
        seed_req = 1'b0;

        // 256 data steps without a seed: step_count wraps to 0.
        for (int k = 0; k < 256; k++) begin
            qd.push_back(R + 40 + 8 * k);
            qp.push_back(R + 41 + 8 * k);
        end
        for (int j = 0; j <= 682; j++) qc.push_back(R + 35 + 3 * j);
        at(R + 2080);
        chk("step_count before wrap", 16'(step_count), 16'd255);
        at(R + 2081);
        chk("step_count wrapped", 16'(step_count), 16'd0);
        at(R + 2082);
        en = 1'b0;

        // Pause: 2-cycle glitch, then a 10-cycle press.
        C = R + 2084;
        at(C);
        en = 1'b1;
        mode_run = 1'b0;
`ifndef PRNG_DEBOUNCE_EN
        qd.push_back(C + 6);
        qc.push_back(C + 6);
        qp.push_back(C + 7);
`endif
        qd.push_back(C + 22 + BL);
        qc.push_back(C + 22 + BL);
        qp.push_back(C + 23 + BL);
        at(C + 4);
        step_btn = 1'b1;
        at(C + 6);
        step_btn = 1'b0;
        at(C + 20);
        step_btn = 1'b1;
        at(C + 30);
        step_btn = 1'b0;
        at(C + 40);
`ifdef PRNG_DEBOUNCE_EN
        chk("step_count after glitch+press", 16'(step_count), 16'd1);
`else
        chk("step_count after glitch+press", 16'(step_count), 16'd2);
`endif
        chk("pause state at end", 16'(state), 16'd3);

        go(5);
        chk("data_step expected pulses missing", 16'(qd.size()), 16'd0);
        chk("ctrl_step expected pulses missing", 16'(qc.size()), 16'd0);
        chk("disp_latch expected pulses missing", 16'(qp.size()), 16'd0);
        chk("seed_load expected pulses missing", 16'(ql.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
